uart64_word_rx: RTL

- Device-side serial receiver for the 64-bit host link. The host serial port transmits each 64-bit word as 8 UART bytes, least-significant byte first.
- Samples the asynchronous serial line (8N1) and assembles 8 bytes into one 64-bit word.
- Presents each word to the system core through a valid/ready handshake with a one-word holding register.
- Sits between the rx_in pin of cray_sys_top and the command/loader logic.

---
 rtl/uart64_word_rx_if.sv | 10 +
 rtl/uart64_word_rx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart64_word_rx_if.sv
// Word handshake between the UART word receiver and its consumer.
`timescale 1ns/1ps
interface uart64_word_rx_if;
  logic [63:0] word_data;
  logic        word_valid;
  logic        word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/uart64_word_rx.sv
// 8N1 serial receiver that packs 8 bytes (LSB byte first) into a 64-bit word.
// Define UART64_RX_TIMEOUT_EN to discard stale partial words and add the timeout pulse.
`timescale 1ns/1ps
module uart64_word_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_in,
  uart64_word_rx_if.master word_if,
  output logic            frame_err,
  output logic            overrun,
  output logic            busy
`ifdef UART64_RX_TIMEOUT_EN
  ,
  output logic            timeout
`endif
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  generate
    if (CLKS_PER_BIT < 8 || TIMEOUT_BITS < 1) begin : g_bad_params
      $error("uart64_word_rx: CLKS_PER_BIT must be >= 8 and TIMEOUT_BITS >= 1");
    end
  endgenerate

  logic          rx_meta;
  logic          rxs;
  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [2:0]    count;
  logic [63:0]   assy;

`ifdef UART64_RX_TIMEOUT_EN
  localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  logic [31:0] idle_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
    end
  end

  assign busy = (count != 3'd0) || (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      timer              <= '0;
      bit_idx            <= '0;
      shift              <= '0;
      count              <= '0;
      assy               <= '0;
      frame_err          <= 1'b0;
      overrun            <= 1'b0;
      word_if.word_data  <= '0;
      word_if.word_valid <= 1'b0;
`ifdef UART64_RX_TIMEOUT_EN
      idle_cnt           <= '0;
      timeout            <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART64_RX_TIMEOUT_EN
      timeout   <= 1'b0;
`endif
      if (word_if.word_valid && word_if.word_ready)
        word_if.word_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            timer <= '0;
`ifdef UART64_RX_TIMEOUT_EN
            idle_cnt <= '0;
          end else if (count != 3'd0) begin
            if (idle_cnt == IDLE_LAST) begin
              count    <= '0;
              idle_cnt <= '0;
              timeout  <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 32'd1;
            end
`endif
          end
        end
        START: begin
          if (timer == T_HALF) begin
            timer <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == T_FULL) begin
            timer          <= '0;
            shift[bit_idx] <= rxs;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == T_FULL) begin
            timer <= '0;
            if (rxs) begin
              state                       <= IDLE;
              count                       <= count + 3'd1;
              assy[{count, 3'b000} +: 8]  <= shift;
              // Last byte: a consumer taking the held word this cycle frees the slot.
              if (count == 3'd7) begin
                if (!word_if.word_valid || word_if.word_ready) begin
                  word_if.word_data  <= {shift, assy[55:0]};
                  word_if.word_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end else begin
              frame_err <= 1'b1;
              count     <= '0;
              state     <= WAIT_IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
